// File: rtl/rv_fetch_buf.sv
// rv_fetch_buf: instruction prefetch queue feeding rv_core decode.
// Fetches aligned words, queues halfwords and re-aligns RVC/32-bit instructions.
// Ports:
//   clk, xreset           clock, async active-high reset
//   i_adr/i_re/i_rdy/i_dr instruction memory port (data one cycle after accept)
//   insn_valid/insn_ready instruction handshake with insn, insn_c, insn_pc
//   redirect/redirect_pc  flush queue and refetch from a new pc
//   level                 halfwords currently queued
module rv_fetch_buf #(
    parameter int          DEPTH    = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     xreset,
    output logic [31:0]              i_adr,
    output logic                     i_re,
    input  logic                     i_rdy,
    input  logic [31:0]              i_dr,
    output logic                     insn_valid,
    input  logic                     insn_ready,
    output logic [31:0]              insn,
    output logic                     insn_c,
    output logic [31:0]              insn_pc,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] rd_q;
    logic [AW-1:0] wr_q;
    logic [CW-1:0] cnt_q;
    logic [31:0]   adr_q;
    logic [31:0]   pc_q;
    logic          infl_q;
    logic          skip_q;
    logic          run_q;

    logic [15:0]   h0;
    logic [15:0]   h1;
    logic          is_c;
    logic          accept;
    logic          push;
    logic          pop;
    logic [CW-1:0] push_n;
    logic [CW-1:0] pop_n;
    logic [CW+1:0] need;

    // Queued halfwords plus the in-flight word plus the new word must fit.
    assign need   = {2'b00, cnt_q} + {{CW{1'b0}}, infl_q, 1'b0}
                  + (CW+2)'(2);
    assign i_re   = run_q && (need <= (CW+2)'(DEPTH));
    assign i_adr  = adr_q;
    assign accept = i_re && i_rdy;

    // A redirect kills both the response landing now and the pop.
    assign push = infl_q && !redirect;

    assign h0   = mem[rd_q];
    assign h1   = mem[rd_q + AW'(1)];
    assign is_c = (h0[1:0] != 2'b11);

    assign insn_valid = is_c ? (cnt_q != '0) : (cnt_q >= CW'(2));
    assign insn       = !insn_valid ? 32'h0
                      : is_c ? {16'h0, h0} : {h1, h0};
    assign insn_c     = insn_valid && is_c;
    assign insn_pc    = pc_q;
    assign level      = cnt_q;

    assign pop    = insn_valid && insn_ready && !redirect;
    assign push_n = !push ? CW'(0) : (skip_q ? CW'(1) : CW'(2));
    assign pop_n  = !pop ? CW'(0) : (is_c ? CW'(1) : CW'(2));

    // Storage needs no reset: entries are only read below cnt_q.
    always_ff @(posedge clk) begin
        if (push) begin
            if (skip_q) begin
                mem[wr_q] <= i_dr[31:16];
            end else begin
                mem[wr_q]          <= i_dr[15:0];
                mem[wr_q + AW'(1)] <= i_dr[31:16];
            end
        end
    end

    always_ff @(posedge clk or posedge xreset) begin
        if (xreset) begin
            rd_q   <= '0;
            wr_q   <= '0;
            cnt_q  <= '0;
            adr_q  <= RESET_PC;
            pc_q   <= RESET_PC;
            infl_q <= 1'b0;
            skip_q <= 1'b0;
            run_q  <= 1'b0;
        end else begin
            run_q <= 1'b1;
            if (redirect) begin
                rd_q   <= '0;
                wr_q   <= '0;
                cnt_q  <= '0;
                adr_q  <= {redirect_pc[31:2], 2'b00};
                pc_q   <= {redirect_pc[31:1], 1'b0};
                infl_q <= 1'b0;
                skip_q <= redirect_pc[1];
            end else begin
                cnt_q  <= cnt_q + push_n - pop_n;
                wr_q   <= wr_q + AW'(push_n);
                rd_q   <= rd_q + AW'(pop_n);
                infl_q <= accept;
                if (accept) adr_q <= adr_q + 32'd4;
                if (pop)    pc_q  <= pc_q + (is_c ? 32'd2 : 32'd4);
                if (push)   skip_q <= 1'b0;
            end
        end
    end

endmodule
